sprite_line_fetch_sched: RTL and testbench
==========================================

Name: sprite_line_fetch_sched

Overview:
Time-shares one sprite-image RAM read port among NUM_SPRITES sprite engines.
- On each linebegin pulse, issues one pipelined read per sprite at that sprite's current line address (its mem_addr output).
- Returns each 16-bit line word on a shared data bus with a one-hot per-sprite line_en strobe.
- Between fetch bursts, grants a CPU write port so software can update sprite bitmaps without tearing.
- Sits between the sprite engines, the sprite RAM and the CPU bus decoder.

Parameters:
NUM_SPRITES, 4, number of sprite engines served (>=1)
ADDR_W, 9, sprite RAM address width
DATA_W, 16, sprite RAM word width (one sprite line)
MEM_LAT, 1, RAM read latency in cycles from mem_rd_en to valid mem_rd_data (>=1)

Ports:
px_clk  in  1  pixel clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
linebegin  in  1  one-cycle pulse at start of each scanline
spr_addr  in  NUM_SPRITES*ADDR_W  per-sprite line address, sprite i at bits [i*ADDR_W +: ADDR_W]
mem_addr  out  ADDR_W  RAM address
mem_rd_en  out  1  RAM read strobe
mem_we  out  1  RAM write strobe
mem_wdata  out  DATA_W  RAM write data
mem_rd_data  in  DATA_W  RAM read data
line_data  out  DATA_W  fetched line word, drives the sprites' data_in
line_en  out  NUM_SPRITES  one-hot load strobe, bit i loads sprite i
cpu_req  in  1  CPU write request, held until ack
cpu_addr  in  ADDR_W  CPU write address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  grant, combinational, high in the cycle the write is performed
busy  out  1  fetch burst in progress
overrun  out  1  sticky: linebegin arrived while busy
ovr_clr  in  1  clears overrun

Behaviour:
- States: IDLE, ISSUE, DRAIN.
- Reset (rst_n low at edge):
  - state=IDLE, issue index=0, latency pipe valid bits cleared, line_en=0, line_data=0, overrun=0, busy=0.
  - Any in-flight fetch is abandoned; no line_en follows reset.
- IDLE:
  - linebegin high at edge k -> ISSUE, index=0.
  - linebegin has priority over cpu_req in the same cycle: no ack that cycle.
  - Otherwise, if cpu_req: cpu_ack=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, all combinational, same cycle.
- ISSUE:
  - For cycles k+1 .. k+NUM_SPRITES: mem_rd_en=1, mem_addr=spr_addr[index]; index increments each cycle.
  - Index is pushed into the MEM_LAT-deep valid/index pipe.
  - After index NUM_SPRITES-1 is issued -> DRAIN.
- DRAIN:
  - No reads issued.
  - Waits until the pipe is empty and the last line_en has been emitted -> IDLE.
- Return path:
  - A read issued in cycle c has its word in mem_rd_data in cycle c+MEM_LAT.
  - In that cycle the word is registered: line_data=word, line_en=onehot(index) during cycle c+MEM_LAT+1.
  - line_en is high for exactly one cycle per sprite, in ascending sprite order, back to back.
  - line_data holds its last value when line_en=0.
- busy: high from k+1 through the cycle of the last line_en inclusive. Burst length is NUM_SPRITES+MEM_LAT+1 cycles.
- Idle outputs: outside ISSUE, mem_rd_en=0. mem_addr=0 when neither reading nor writing.
- cpu_ack: 0 in ISSUE and DRAIN.
- linebegin while not IDLE: ignored, no restart; overrun set to 1.
  - ovr_clr clears overrun next edge.
  - Simultaneous set and clear: set wins.
- NUM_SPRITES=1:
  - Index width is max(1, clog2(NUM_SPRITES)).
  - ISSUE lasts 1 cycle.
- spr_addr is sampled at issue time only; changes elsewhere have no effect.

Decomposition:
- Shared package sprite_pkg:
  - state enum (IDLE/ISSUE/DRAIN)
  - default ADDR_W/DATA_W constants
  - index-width function (max(1,clog2))
- One sub-module sprite_fetch_pipe: a MEM_LAT-deep shift register of {valid, index}, with synchronous active-low clear.
- The FSM, CPU mux and output registers live in the top module.

Test Plan:
1. Fetch order and data. NUM_SPRITES=4, MEM_LAT=1, spr_addr={0x0d0,0x0c0,0x0b0,0x0a0}, RAM[0x0a0]=0x8001, RAM[0x0b0]=0x4002, RAM[0x0c0]=0x2004, RAM[0x0d0]=0x1008. Pulse linebegin at cycle 10 -> reads at 11-14 on addresses 0a0,0b0,0c0,0d0; line_en=0001,0010,0100,1000 at cycles 13-16 with the matching line_data; busy high 11-16.
2. CPU write in IDLE. cpu_req, addr 0x0a5, data 0xBEEF in IDLE -> same-cycle cpu_ack=1, mem_we=1; later fetch of 0x0a5 returns 0xBEEF.
3. Simultaneous linebegin and cpu_req -> no ack during the burst; ack in the first IDLE cycle after busy falls.
4. Overrun. linebegin during ISSUE -> overrun=1 and burst unaffected (still exactly 4 line_en). ovr_clr -> overrun=0 next cycle.
5. Reset mid-burst. rst_n low at cycle 12 of scenario 1 -> no further line_en, busy=0, state IDLE. The next linebegin produces a full clean burst.
6. Latency 2. MEM_LAT=2, NUM_SPRITES=1 -> linebegin at cycle 5 gives read at 6 and line_en=1 at cycle 9; busy high for cycles 6-9.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line fetch scheduler.
//   state_e    : scheduler FSM states
//   SPR_ADDR_W : default sprite RAM address width
//   SPR_DATA_W : default sprite RAM word width (one sprite line)
//   idx_width  : width of a sprite index, never narrower than one bit
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int SPR_ADDR_W = 9;
  localparam int SPR_DATA_W = 16;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sprite_line_fetch_sched_if.sv
// Bus bundle between the scheduler, the sprite RAM port and the CPU write decoder.
//   mem_addr/mem_rd_en/mem_we/mem_wdata : RAM command, driven by the scheduler
//   mem_rd_data                         : RAM read data, driven by the RAM
//   cpu_req/cpu_addr/cpu_wdata          : CPU write request, held until cpu_ack
//   cpu_ack                             : write grant, driven by the scheduler
// master = scheduler side, slave = RAM / CPU side.
interface sprite_line_fetch_sched_if
  import sprite_pkg::*;
#(
  parameter int ADDR_W = SPR_ADDR_W,
  parameter int DATA_W = SPR_DATA_W
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rd_data;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;

  modport master (
    output mem_addr, mem_rd_en, mem_we, mem_wdata, cpu_ack,
    input  mem_rd_data, cpu_req, cpu_addr, cpu_wdata
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_we, mem_wdata, cpu_ack,
    output mem_rd_data, cpu_req, cpu_addr, cpu_wdata
  );
endinterface

// File: rtl/sprite_fetch_pipe.sv
// DEPTH-deep shift register of {valid, sprite index} that tracks reads in
// flight through the RAM. Stage DEPTH-1 lines up with the cycle in which the
// RAM presents the read word.
//   clk      : clock
//   clr_n    : synchronous active-low clear of the valid bits
//   push_vld : a read is issued this cycle
//   push_idx : sprite index of that read
//   out_vld  : the RAM word on the bus this cycle belongs to a tracked read
//   out_idx  : sprite index of that word
//   any_vld  : at least one read still in flight
module sprite_fetch_pipe
  import sprite_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int IDX_W = idx_width(4)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             push_vld,
  input  logic [IDX_W-1:0] push_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx,
  output logic             any_vld
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [IDX_W-1:0] idx_q [DEPTH];
  logic [IDX_W-1:0] idx_d [DEPTH];

  always_comb begin
    vld_d    = '0;
    idx_d    = '{default: '0};
    vld_d[0] = push_vld;
    idx_d[0] = push_idx;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  // The index rides along with its valid bit, so it needs no clear.
  always_ff @(posedge clk) begin
    idx_q <= idx_d;
  end

  assign out_vld = vld_q[DEPTH-1];
  assign out_idx = idx_q[DEPTH-1];
  assign any_vld = |vld_q;

endmodule

// File: rtl/sprite_line_fetch_sched.sv
// Time-shares one sprite RAM read port among NUM_SPRITES sprite engines.
// On linebegin one read per sprite is issued back to back; each returned word
// is registered onto line_data with a one-hot line_en strobe. Between bursts
// the RAM port is lent to the CPU for writes.
//   px_clk, rst_n : clock, synchronous active-low reset
//   linebegin     : one-cycle pulse at the start of a scanline
//   spr_addr      : per-sprite line address, sprite i at [i*ADDR_W +: ADDR_W]
//   bus           : RAM command/data and CPU write handshake (master side)
//   line_data     : fetched line word, held between strobes
//   line_en       : one-hot load strobe per sprite
//   busy          : fetch burst in progress
//   overrun       : sticky, linebegin seen while busy; ovr_clr clears it
module sprite_line_fetch_sched
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int ADDR_W      = SPR_ADDR_W,
  parameter int DATA_W      = SPR_DATA_W,
  parameter int MEM_LAT     = 1
) (
  input  logic                          px_clk,
  input  logic                          rst_n,
  input  logic                          linebegin,
  input  logic [NUM_SPRITES*ADDR_W-1:0] spr_addr,
  sprite_line_fetch_sched_if.master     bus,
  output logic [DATA_W-1:0]             line_data,
  output logic [NUM_SPRITES-1:0]        line_en,
  output logic                          busy,
  output logic                          overrun,
  input  logic                          ovr_clr
);

  localparam int             IW       = idx_width(NUM_SPRITES);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_SPRITES - 1);

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     ovr_q, ovr_d;
  logic [DATA_W-1:0]        line_data_q, line_data_d;
  logic [NUM_SPRITES-1:0]   line_en_q, line_en_d;
  logic                     issue;
  logic                     pipe_vld;
  logic [IW-1:0]            pipe_idx;
  logic                     pipe_any;

  sprite_fetch_pipe #(
    .DEPTH (MEM_LAT),
    .IDX_W (IW)
  ) u_pipe (
    .clk      (px_clk),
    .clr_n    (rst_n),
    .push_vld (issue),
    .push_idx (idx_q),
    .out_vld  (pipe_vld),
    .out_idx  (pipe_idx),
    .any_vld  (pipe_any)
  );

  // FSM and RAM port mux: reads in ISSUE, CPU writes only in IDLE.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    issue         = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_rd_en = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.cpu_ack   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // linebegin wins the port over a pending CPU write.
        if (linebegin) begin
          state_d = ISSUE;
          idx_d   = '0;
        end else if (bus.cpu_req) begin
          bus.cpu_ack   = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = bus.cpu_addr;
          bus.mem_wdata = bus.cpu_wdata;
        end
      end
      ISSUE: begin
        issue         = 1'b1;
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = spr_addr[idx_q*ADDR_W +: ADDR_W];
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        // Once the pipe is empty the final word was registered last edge,
        // so its line_en is on the output during this cycle.
        if (!pipe_any) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Return path and sticky overrun; a new overrun beats a same-cycle clear.
  always_comb begin
    line_en_d   = pipe_vld ? (NUM_SPRITES'(1) << pipe_idx) : '0;
    line_data_d = pipe_vld ? bus.mem_rd_data : line_data_q;
    ovr_d       = ovr_q;
    if (ovr_clr) ovr_d = 1'b0;
    if (linebegin && (state_q != IDLE)) ovr_d = 1'b1;
  end

  always_ff @(posedge px_clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ovr_q       <= 1'b0;
      line_en_q   <= '0;
      line_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ovr_q       <= ovr_d;
      line_en_q   <= line_en_d;
      line_data_q <= line_data_d;
    end
  end

  assign line_data = line_data_q;
  assign line_en   = line_en_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sprite_line_fetch_sched.sv
// Directed bench: DUT A (4 sprites, latency 1) and DUT B (1 sprite, latency 2),
// each against a behavioural RAM. Returned line words are checked against a
// scoreboard of {cycle, strobe, data} filled when linebegin is driven.
module tb_sprite_line_fetch_sched;
  import sprite_pkg::*;

  localparam int NS = 4;
  localparam int AW = 9;
  localparam int DW = 16;

  typedef struct {
    int          cyc;
    logic [3:0]  en;
    logic [15:0] data;
  } exp_t;

  logic px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  int cyc = 0;
  always @(posedge px_clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  logic              rst_n;
  logic              lb_a, ovr_clr_a;
  logic [NS*AW-1:0]  spr_a;
  logic [DW-1:0]     line_data_a;
  logic [NS-1:0]     line_en_a;
  logic              busy_a, ovr_a;

  logic              lb_b, ovr_clr_b;
  logic [AW-1:0]     spr_b;
  logic [DW-1:0]     line_data_b;
  logic [0:0]        line_en_b;
  logic              busy_b, ovr_b;

  sprite_line_fetch_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  sprite_line_fetch_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  sprite_line_fetch_sched #(.NUM_SPRITES(NS), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut_a (
    .px_clk(px_clk), .rst_n(rst_n), .linebegin(lb_a), .spr_addr(spr_a), .bus(bus_a),
    .line_data(line_data_a), .line_en(line_en_a), .busy(busy_a), .overrun(ovr_a),
    .ovr_clr(ovr_clr_a)
  );

  sprite_line_fetch_sched #(.NUM_SPRITES(1), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) dut_b (
    .px_clk(px_clk), .rst_n(rst_n), .linebegin(lb_b), .spr_addr(spr_b), .bus(bus_b),
    .line_data(line_data_b), .line_en(line_en_b), .busy(busy_b), .overrun(ovr_b),
    .ovr_clr(ovr_clr_b)
  );

  // Power-up RAM image shared by both RAM models.
  function automatic logic [15:0] rom(input logic [8:0] a);
    case (a)
      9'h0a0:  return 16'h8001;
      9'h0b0:  return 16'h4002;
      9'h0c0:  return 16'h2004;
      9'h0d0:  return 16'h1008;
      9'h1c3:  return 16'h5aa5;
      default: return 16'h0000;
    endcase
  endfunction

  // RAM A: latency 1, writable.
  bit        wr_vld_a [512];
  bit [15:0] wr_ram_a [512];
  bit [15:0] rd_a;
  always @(posedge px_clk) begin
    if (bus_a.mem_we) begin
      wr_ram_a[bus_a.mem_addr] <= bus_a.mem_wdata;
      wr_vld_a[bus_a.mem_addr] <= 1'b1;
    end
    if (bus_a.mem_rd_en)
      rd_a <= wr_vld_a[bus_a.mem_addr] ? wr_ram_a[bus_a.mem_addr] : rom(bus_a.mem_addr);
  end
  assign bus_a.mem_rd_data = rd_a;

  // RAM B: latency 2, read only.
  bit [15:0] rd_b1, rd_b2;
  always @(posedge px_clk) begin
    if (bus_b.mem_rd_en) rd_b1 <= rom(bus_b.mem_addr);
    rd_b2 <= rd_b1;
  end
  assign bus_b.mem_rd_data = rd_b2;

  // Bench-side reference of CPU writes made so far.
  logic [15:0] ref_wr [logic [8:0]];
  exp_t sb_a[$];
  exp_t sb_b[$];

  function automatic logic [15:0] ref_val(input logic [8:0] a);
    return ref_wr.exists(a) ? ref_wr[a] : rom(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input int k);
    logic [8:0] a;
    for (int i = 0; i < NS; i++) begin
      a = spr_a[i*AW +: AW];
      sb_a.push_back('{k + 3 + i, 4'(1 << i), ref_val(a)});
    end
  endtask

  // Line-word monitors.
  always @(negedge px_clk) begin
    exp_t e;
    if (line_en_a !== 4'b0) begin
      chk("a_line_en_expected", 32'(sb_a.size() != 0), 32'd1);
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        chk("a_line_en", 32'(line_en_a), 32'(e.en));
        chk("a_line_data", 32'(line_data_a), 32'(e.data));
        chk("a_line_cycle", cyc, e.cyc);
      end
    end
    if (line_en_b !== 1'b0) begin
      chk("b_line_en_expected", 32'(sb_b.size() != 0), 32'd1);
      if (sb_b.size() != 0) begin
        e = sb_b.pop_front();
        chk("b_line_en", 32'(line_en_b), 32'(e.en));
        chk("b_line_data", 32'(line_data_b), 32'(e.data));
        chk("b_line_cycle", cyc, e.cyc);
      end
    end
  end

  // Full burst on DUT A starting in the current cycle. ovr_at>0 also raises
  // linebegin and ovr_clr together in that burst cycle.
  task automatic burst_a(input int ovr_at);
    int k;
    logic exp_wr;
    k = cyc;
    lb_a = 1'b1;
    push_a(k);
    @(negedge px_clk);
    chk("a_busy_k", 32'(busy_a), 32'd0);
    chk("a_ack_at_lb", 32'(bus_a.cpu_ack), 32'd0);
    for (int c = 1; c <= 7; c++) begin
      @(posedge px_clk); #1;
      lb_a      = (c == ovr_at);
      ovr_clr_a = (c == ovr_at);
      @(negedge px_clk);
      exp_wr = (c == 7) && bus_a.cpu_req;
      chk("a_busy", 32'(busy_a), 32'(c <= 6));
      chk("a_rd_en", 32'(bus_a.mem_rd_en), 32'(c <= 4));
      chk("a_ack", 32'(bus_a.cpu_ack), 32'(exp_wr));
      chk("a_we", 32'(bus_a.mem_we), 32'(exp_wr));
      if (c <= 4) chk("a_rd_addr", 32'(bus_a.mem_addr), 32'(spr_a[(c-1)*AW +: AW]));
      else chk("a_idle_addr", 32'(bus_a.mem_addr), exp_wr ? 32'(bus_a.cpu_addr) : 32'd0);
      if (ovr_at > 0 && c == ovr_at + 1) chk("a_ovr_set_wins", 32'(ovr_a), 32'd1);
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    lb_a = 1'b0; ovr_clr_a = 1'b0;
    lb_b = 1'b0; ovr_clr_b = 1'b0;
    spr_a = {9'h0d0, 9'h0c0, 9'h0b0, 9'h0a0};
    spr_b = 9'h1c3;
    bus_a.cpu_req = 1'b0; bus_a.cpu_addr = '0; bus_a.cpu_wdata = '0;
    bus_b.cpu_req = 1'b0; bus_b.cpu_addr = '0; bus_b.cpu_wdata = '0;

    repeat (3) @(posedge px_clk);
    #1 rst_n = 1'b1;
    @(negedge px_clk);
    chk("rst_a_line_en", 32'(line_en_a), 32'd0);
    chk("rst_a_line_data", 32'(line_data_a), 32'd0);
    chk("rst_a_busy", 32'(busy_a), 32'd0);
    chk("rst_a_overrun", 32'(ovr_a), 32'd0);
    chk("rst_a_rd_en", 32'(bus_a.mem_rd_en), 32'd0);
    chk("rst_a_mem_addr", 32'(bus_a.mem_addr), 32'd0);
    chk("rst_b_busy", 32'(busy_b), 32'd0);
    chk("rst_b_line_en", 32'(line_en_b), 32'd0);

    // Fetch order and data, linebegin in cycle 10.
    while (cyc < 10) begin @(posedge px_clk); #1; end
    burst_a(0);

    // CPU write in IDLE, then fetch it back through sprite 0.
    @(posedge px_clk); #1;
    bus_a.cpu_req = 1'b1; bus_a.cpu_addr = 9'h0a5; bus_a.cpu_wdata = 16'hBEEF;
    @(negedge px_clk);
    chk("cpu_ack", 32'(bus_a.cpu_ack), 32'd1);
    chk("cpu_we", 32'(bus_a.mem_we), 32'd1);
    chk("cpu_addr", 32'(bus_a.mem_addr), 32'h0a5);
    chk("cpu_wdata", 32'(bus_a.mem_wdata), 32'hBEEF);
    @(posedge px_clk); #1;
    bus_a.cpu_req = 1'b0;
    ref_wr[9'h0a5] = 16'hBEEF;
    spr_a[0 +: AW] = 9'h0a5;
    @(negedge px_clk);
    chk("cpu_ack_drop", 32'(bus_a.cpu_ack), 32'd0);
    chk("cpu_we_drop", 32'(bus_a.mem_we), 32'd0);
    @(posedge px_clk); #1;
    burst_a(0);

    // linebegin together with cpu_req: ack only after the burst.
    @(posedge px_clk); #1;
    bus_a.cpu_req = 1'b1; bus_a.cpu_addr = 9'h0b5; bus_a.cpu_wdata = 16'h1234;
    burst_a(0);
    @(posedge px_clk); #1;
    bus_a.cpu_req = 1'b0;
    ref_wr[9'h0b5] = 16'h1234;

    // Overrun during ISSUE (sprite 1 now reads the CPU-written word).
    spr_a[AW +: AW] = 9'h0b5;
    @(posedge px_clk); #1;
    burst_a(2);
    chk("ovr_sticky", 32'(ovr_a), 32'd1);
    @(posedge px_clk); #1;
    ovr_clr_a = 1'b1;
    @(negedge px_clk);
    chk("ovr_before_clr_edge", 32'(ovr_a), 32'd1);
    @(posedge px_clk); #1;
    ovr_clr_a = 1'b0;
    @(negedge px_clk);
    chk("ovr_cleared", 32'(ovr_a), 32'd0);

    // Reset two cycles into a burst: nothing may come back.
    @(posedge px_clk); #1;
    lb_a = 1'b1;
    @(posedge px_clk); #1;
    lb_a = 1'b0;
    @(posedge px_clk); #1;
    rst_n = 1'b0;
    @(posedge px_clk); #1;
    rst_n = 1'b1;
    @(negedge px_clk);
    chk("mrst_busy", 32'(busy_a), 32'd0);
    chk("mrst_line_en", 32'(line_en_a), 32'd0);
    chk("mrst_line_data", 32'(line_data_a), 32'd0);
    chk("mrst_rd_en", 32'(bus_a.mem_rd_en), 32'd0);
    repeat (5) @(posedge px_clk);
    #1;
    @(negedge px_clk);
    chk("mrst_busy_later", 32'(busy_a), 32'd0);
    @(posedge px_clk); #1;
    burst_a(0);

    // Latency 2, single sprite.
    @(posedge px_clk); #1;
    k = cyc;
    lb_b = 1'b1;
    sb_b.push_back('{k + 4, 4'd1, rom(9'h1c3)});
    @(negedge px_clk);
    chk("b_busy_k", 32'(busy_b), 32'd0);
    for (int c = 1; c <= 5; c++) begin
      @(posedge px_clk); #1;
      lb_b = 1'b0;
      @(negedge px_clk);
      chk("b_busy", 32'(busy_b), 32'(c <= 4));
      chk("b_rd_en", 32'(bus_b.mem_rd_en), 32'(c == 1));
      if (c == 1) chk("b_rd_addr", 32'(bus_b.mem_addr), 32'h1c3);
    end

    repeat (3) @(posedge px_clk);
    @(negedge px_clk);
    chk("a_scoreboard_empty", 32'(sb_a.size()), 32'd0);
    chk("b_scoreboard_empty", 32'(sb_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
